// File: rtl/load_store_dmem_ctrl.sv
// Arbitrates the single dcache port between load RS requests and store-buffer drains.
// Optional perf counters are enabled by defining LSQ_DMEM_PERF_EN.
module load_store_dmem_ctrl #(
    parameter int LOAD_RS_DEPTH = 3,
    parameter int STARVE_MAX    = 4,
    parameter int STARVE_W      = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     move_flush,
    input  logic                     dmem_r_rqst,
    input  logic [LOAD_RS_DEPTH-1:0] load_rs_dmem_idx_rqst,
    input  logic [31:0]              arbiter_load_rs_addr,
    input  logic [3:0]               arbiter_load_rs_rmask,
    input  logic                     store_buffer_w_rqst,
    input  logic                     store_buffer_full,
    input  logic [31:0]              store_buffer_head_addr,
    input  logic [3:0]               store_buffer_head_wmask,
    input  logic [31:0]              store_buffer_head_wdata,
    output logic                     store_buffer_pop,
    output logic                     load_rs_dmem_ready,
    output logic [LOAD_RS_DEPTH-1:0] load_rs_dmem_idx_executing,
    output logic [31:0]              dmem_addr,
    output logic [3:0]               dmem_rmask,
    output logic [3:0]               dmem_wmask,
    output logic [31:0]              dmem_wdata,
`ifdef LSQ_DMEM_PERF_EN
    output logic [31:0]              perf_load_cnt,
    output logic [31:0]              perf_store_cnt,
    output logic [31:0]              perf_flush_drop_cnt,
`endif
    input  logic                     dmem_resp
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        LOAD_WAIT  = 2'd1,
        STORE_WAIT = 2'd2,
        FLUSH_WAIT = 2'd3
    } state_t;

    localparam logic [STARVE_W-1:0] STARVE_LIMIT = STARVE_W'(STARVE_MAX);

    state_t                   state_r;
    logic [STARVE_W-1:0]      starve_cnt_r;
    logic [STARVE_W-1:0]      starve_cnt_next_s;
    logic [LOAD_RS_DEPTH-1:0] idx_r;
    logic [31:0]              addr_r;
    logic [3:0]               rmask_r;
    logic [3:0]               wmask_r;
    logic [31:0]              wdata_r;
    logic                     store_grant_s;
    logic                     load_grant_s;
    logic                     ready_s;
    logic                     pop_s;
    logic                     drop_s;

    // Grant decisions, completion pulses and starvation counter next value.
    always_comb begin
        store_grant_s     = 1'b0;
        load_grant_s      = 1'b0;
        starve_cnt_next_s = starve_cnt_r;
        if (state_r == IDLE) begin
            // Flush only blocks loads; a committed store may still go out.
            store_grant_s = store_buffer_w_rqst &&
                            (!dmem_r_rqst || store_buffer_full || (starve_cnt_r == STARVE_LIMIT));
            load_grant_s  = !store_grant_s && dmem_r_rqst && !move_flush;
        end else begin
            store_grant_s = 1'b0;
            load_grant_s  = 1'b0;
        end
        if (!store_buffer_w_rqst || store_grant_s) begin
            starve_cnt_next_s = {STARVE_W{1'b0}};
        end else if (load_grant_s && (starve_cnt_r != STARVE_LIMIT)) begin
            starve_cnt_next_s = starve_cnt_r + {{(STARVE_W-1){1'b0}}, 1'b1};
        end else begin
            starve_cnt_next_s = starve_cnt_r;
        end
        ready_s = !rst && (state_r == LOAD_WAIT) && dmem_resp && !move_flush;
        pop_s   = !rst && (state_r == STORE_WAIT) && dmem_resp;
        drop_s  = !rst && dmem_resp &&
                  ((state_r == FLUSH_WAIT) || ((state_r == LOAD_WAIT) && move_flush));
    end

    // Request sequencing FSM with holding registers that drive the dcache port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            starve_cnt_r <= {STARVE_W{1'b0}};
            idx_r        <= {LOAD_RS_DEPTH{1'b0}};
            addr_r       <= 32'h0000_0000;
            rmask_r      <= 4'b0000;
            wmask_r      <= 4'b0000;
            wdata_r      <= 32'h0000_0000;
        end else begin
            starve_cnt_r <= starve_cnt_next_s;
            case (state_r)
                IDLE: begin
                    if (store_grant_s) begin
                        state_r <= STORE_WAIT;
                        addr_r  <= {store_buffer_head_addr[31:2], 2'b00};
                        rmask_r <= 4'b0000;
                        wmask_r <= store_buffer_head_wmask;
                        wdata_r <= store_buffer_head_wdata;
                    end else if (load_grant_s) begin
                        state_r <= LOAD_WAIT;
                        idx_r   <= load_rs_dmem_idx_rqst;
                        addr_r  <= {arbiter_load_rs_addr[31:2], 2'b00};
                        rmask_r <= arbiter_load_rs_rmask;
                        wmask_r <= 4'b0000;
                        wdata_r <= 32'h0000_0000;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                LOAD_WAIT: begin
                    if (dmem_resp) begin
                        state_r <= IDLE;
                        addr_r  <= 32'h0000_0000;
                        rmask_r <= 4'b0000;
                        wmask_r <= 4'b0000;
                        wdata_r <= 32'h0000_0000;
                    end else if (move_flush) begin
                        state_r <= FLUSH_WAIT;
                    end else begin
                        state_r <= LOAD_WAIT;
                    end
                end
                STORE_WAIT, FLUSH_WAIT: begin
                    if (dmem_resp) begin
                        state_r <= IDLE;
                        addr_r  <= 32'h0000_0000;
                        rmask_r <= 4'b0000;
                        wmask_r <= 4'b0000;
                        wdata_r <= 32'h0000_0000;
                    end else begin
                        state_r <= state_r;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

`ifdef LSQ_DMEM_PERF_EN
    logic [31:0] perf_load_r;
    logic [31:0] perf_store_r;
    logic [31:0] perf_drop_r;

    // Wrapping event counters for completed loads, pops and dropped responses.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_load_r  <= 32'd0;
            perf_store_r <= 32'd0;
            perf_drop_r  <= 32'd0;
        end else begin
            perf_load_r  <= perf_load_r  + {31'd0, ready_s};
            perf_store_r <= perf_store_r + {31'd0, pop_s};
            perf_drop_r  <= perf_drop_r  + {31'd0, drop_s};
        end
    end

    assign perf_load_cnt       = perf_load_r;
    assign perf_store_cnt      = perf_store_r;
    assign perf_flush_drop_cnt = perf_drop_r;
`else
    logic unused_drop_s;
    assign unused_drop_s = drop_s;
`endif

    assign load_rs_dmem_ready         = ready_s;
    assign load_rs_dmem_idx_executing = ready_s ? idx_r : {LOAD_RS_DEPTH{1'b0}};
    assign store_buffer_pop           = pop_s;
    assign dmem_addr                  = addr_r;
    assign dmem_rmask                 = rmask_r;
    assign dmem_wmask                 = wmask_r;
    assign dmem_wdata                 = wdata_r;

endmodule

// File: tb/tb_load_store_dmem_ctrl.sv
// Directed self-checking bench for load_store_dmem_ctrl (perf checks when LSQ_DMEM_PERF_EN is set).
module tb_load_store_dmem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        move_flush;
    logic        dmem_r_rqst;
    logic [2:0]  idx_rqst;
    logic [31:0] ld_addr;
    logic [3:0]  ld_rmask;
    logic        w_rqst;
    logic        sb_full;
    logic [31:0] st_addr;
    logic [3:0]  st_wmask;
    logic [31:0] st_wdata;
    logic        sb_pop;
    logic        ld_ready;
    logic [2:0]  idx_exec;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_rmask;
    logic [3:0]  dmem_wmask;
    logic [31:0] dmem_wdata;
    logic        dmem_resp;
`ifdef LSQ_DMEM_PERF_EN
    logic [31:0] perf_load_cnt;
    logic [31:0] perf_store_cnt;
    logic [31:0] perf_flush_drop_cnt;
`endif

    int total = 0;
    int bad   = 0;

    load_store_dmem_ctrl dut (
        .clk                        (clk),
        .rst                        (rst),
        .move_flush                 (move_flush),
        .dmem_r_rqst                (dmem_r_rqst),
        .load_rs_dmem_idx_rqst      (idx_rqst),
        .arbiter_load_rs_addr       (ld_addr),
        .arbiter_load_rs_rmask      (ld_rmask),
        .store_buffer_w_rqst        (w_rqst),
        .store_buffer_full          (sb_full),
        .store_buffer_head_addr     (st_addr),
        .store_buffer_head_wmask    (st_wmask),
        .store_buffer_head_wdata    (st_wdata),
        .store_buffer_pop           (sb_pop),
        .load_rs_dmem_ready         (ld_ready),
        .load_rs_dmem_idx_executing (idx_exec),
        .dmem_addr                  (dmem_addr),
        .dmem_rmask                 (dmem_rmask),
        .dmem_wmask                 (dmem_wmask),
        .dmem_wdata                 (dmem_wdata),
`ifdef LSQ_DMEM_PERF_EN
        .perf_load_cnt              (perf_load_cnt),
        .perf_store_cnt             (perf_store_cnt),
        .perf_flush_drop_cnt        (perf_flush_drop_cnt),
`endif
        .dmem_resp                  (dmem_resp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic mid;
        @(negedge clk);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_addr"},  dmem_addr,  32'h0000_0000);
        chk({tag, "_rmask"}, {28'd0, dmem_rmask}, 32'd0);
        chk({tag, "_wmask"}, {28'd0, dmem_wmask}, 32'd0);
        chk({tag, "_wdata"}, dmem_wdata, 32'h0000_0000);
        chk({tag, "_ready"}, {31'd0, ld_ready}, 32'd0);
        chk({tag, "_pop"},   {31'd0, sb_pop},   32'd0);
        chk({tag, "_idx"},   {29'd0, idx_exec}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; move_flush = 1'b0; dmem_r_rqst = 1'b0; idx_rqst = 3'd0;
        ld_addr = 32'h0; ld_rmask = 4'h0; w_rqst = 1'b0; sb_full = 1'b0;
        st_addr = 32'h0; st_wmask = 4'h0; st_wdata = 32'h0; dmem_resp = 1'b0;
        tick; tick; tick;
        rst = 1'b0;
        mid; chk_idle_outputs("reset");

        // Single load: idx 5, unaligned address, response three cycles later
        tick; dmem_r_rqst = 1'b1; idx_rqst = 3'd5; ld_addr = 32'h0000_1006; ld_rmask = 4'b0100;
        tick; dmem_r_rqst = 1'b0;
        mid; chk("ld1_addr", dmem_addr, 32'h0000_1004);
        chk("ld1_rmask", {28'd0, dmem_rmask}, 32'h4);
        chk("ld1_wmask", {28'd0, dmem_wmask}, 32'h0);
        chk("ld1_noready", {31'd0, ld_ready}, 32'd0);
        tick; tick;
        tick; dmem_resp = 1'b1;
        mid; chk("ld1_ready", {31'd0, ld_ready}, 32'd1);
        chk("ld1_idx", {29'd0, idx_exec}, 32'd5);
        tick; dmem_resp = 1'b0;
        mid; chk_idle_outputs("ld1_idle");

        // Concurrent load and store, buffer not full: load first, then store
        dmem_r_rqst = 1'b1; idx_rqst = 3'd2; ld_addr = 32'h0000_2000; ld_rmask = 4'hF;
        w_rqst = 1'b1; st_addr = 32'h0000_3009; st_wmask = 4'b0011; st_wdata = 32'hDEAD_BEEF;
        tick; dmem_r_rqst = 1'b0;
        mid; chk("cc_ld_addr", dmem_addr, 32'h0000_2000);
        chk("cc_ld_rmask", {28'd0, dmem_rmask}, 32'hF);
        chk("cc_ld_wmask", {28'd0, dmem_wmask}, 32'h0);
        tick; dmem_resp = 1'b1;
        mid; chk("cc_ld_ready", {31'd0, ld_ready}, 32'd1);
        chk("cc_ld_idx", {29'd0, idx_exec}, 32'd2);
        tick; dmem_resp = 1'b0;
        mid; chk("cc_bubble_addr", dmem_addr, 32'h0);
        tick;
        mid; chk("cc_st_addr", dmem_addr, 32'h0000_3008);
        chk("cc_st_wmask", {28'd0, dmem_wmask}, 32'h3);
        chk("cc_st_rmask", {28'd0, dmem_rmask}, 32'h0);
        chk("cc_st_wdata", dmem_wdata, 32'hDEAD_BEEF);
        chk("cc_st_nopop", {31'd0, sb_pop}, 32'd0);
        tick; dmem_resp = 1'b1;
        mid; chk("cc_st_pop", {31'd0, sb_pop}, 32'd1);
        tick; dmem_resp = 1'b0; w_rqst = 1'b0;
        mid; chk("cc_st_pop_once", {31'd0, sb_pop}, 32'd0);
        chk("cc_st_idle_addr", dmem_addr, 32'h0);

        // Starvation: four load grants, then the store is forced
        dmem_r_rqst = 1'b1; w_rqst = 1'b1; idx_rqst = 3'd1; ld_addr = 32'h0000_0100; ld_rmask = 4'hF;
        for (int i = 0; i < 4; i++) begin
            tick;
            mid; chk($sformatf("stv_ld%0d_rmask", i), {28'd0, dmem_rmask}, 32'hF);
            chk($sformatf("stv_ld%0d_wmask", i), {28'd0, dmem_wmask}, 32'h0);
            tick; dmem_resp = 1'b1;
            mid; chk($sformatf("stv_ld%0d_ready", i), {31'd0, ld_ready}, 32'd1);
            tick; dmem_resp = 1'b0;
        end
        tick;
        mid; chk("stv_st_wmask", {28'd0, dmem_wmask}, 32'h3);
        chk("stv_st_rmask", {28'd0, dmem_rmask}, 32'h0);
        tick; dmem_resp = 1'b1;
        mid; chk("stv_st_pop", {31'd0, sb_pop}, 32'd1);
        tick; dmem_resp = 1'b0;
        tick;
        mid; chk("stv_cnt_clr_rmask", {28'd0, dmem_rmask}, 32'hF);
        chk("stv_cnt_clr_wmask", {28'd0, dmem_wmask}, 32'h0);
        tick; dmem_resp = 1'b1;
        mid; chk("stv_cnt_clr_ready", {31'd0, ld_ready}, 32'd1);
        tick; dmem_resp = 1'b0; sb_full = 1'b1;

        // Buffer full: store wins with both requesting
        tick;
        mid; chk("full_wmask", {28'd0, dmem_wmask}, 32'h3);
        chk("full_rmask", {28'd0, dmem_rmask}, 32'h0);
        tick; dmem_resp = 1'b1;
        mid; chk("full_pop", {31'd0, sb_pop}, 32'd1);
        tick; dmem_resp = 1'b0; sb_full = 1'b0; w_rqst = 1'b0; dmem_r_rqst = 1'b0;

        // Flush mid-load: flush two cycles after grant, response later
        tick; dmem_r_rqst = 1'b1; idx_rqst = 3'd3; ld_addr = 32'h0000_4000; ld_rmask = 4'b0001;
        tick; dmem_r_rqst = 1'b0;
        mid; chk("fl_rmask", {28'd0, dmem_rmask}, 32'h1);
        tick;
        tick; move_flush = 1'b1;
        mid; chk("fl_noready0", {31'd0, ld_ready}, 32'd0);
        tick; move_flush = 1'b0;
        mid; chk("fl_held_addr", dmem_addr, 32'h0000_4000);
        tick; dmem_resp = 1'b1;
        mid; chk("fl_resp_noready", {31'd0, ld_ready}, 32'd0);
        tick; dmem_resp = 1'b0;
        mid; chk_idle_outputs("fl_idle");

        // Flush in IDLE blocks the load grant
        dmem_r_rqst = 1'b1; move_flush = 1'b1; idx_rqst = 3'd4; ld_addr = 32'h0000_4444;
        tick; move_flush = 1'b0;
        mid; chk("idleflush_nogrant", {28'd0, dmem_rmask}, 32'h0);
        tick; dmem_r_rqst = 1'b0;
        mid; chk("col_addr", dmem_addr, 32'h0000_4444);
        // Flush and response in the same cycle
        tick; move_flush = 1'b1; dmem_resp = 1'b1;
        mid; chk("col_noready", {31'd0, ld_ready}, 32'd0);
        tick; move_flush = 1'b0; dmem_resp = 1'b0;
        mid; chk_idle_outputs("col_idle");

        // Flush during STORE_WAIT still pops
        w_rqst = 1'b1; st_addr = 32'h0000_6004; st_wmask = 4'b1000; st_wdata = 32'h1234_5678;
        tick; move_flush = 1'b1;
        mid; chk("stfl_wmask", {28'd0, dmem_wmask}, 32'h8);
        tick;
        mid; chk("stfl_held_wdata", dmem_wdata, 32'h1234_5678);
        tick; dmem_resp = 1'b1;
        mid; chk("stfl_pop", {31'd0, sb_pop}, 32'd1);
        tick; dmem_resp = 1'b0; move_flush = 1'b0; w_rqst = 1'b0;
        mid; chk_idle_outputs("stfl_idle");

        // Reset mid-LOAD_WAIT, response in the reset cycle and later in IDLE
        dmem_r_rqst = 1'b1; idx_rqst = 3'd6; ld_addr = 32'h0000_5000; ld_rmask = 4'hF;
        tick; dmem_r_rqst = 1'b0;
        mid; chk("rst_ld_rmask", {28'd0, dmem_rmask}, 32'hF);
        tick; rst = 1'b1; dmem_resp = 1'b1;
        mid; chk("rst_cycle_noready", {31'd0, ld_ready}, 32'd0);
        tick; rst = 1'b0; dmem_resp = 1'b0;
        mid; chk_idle_outputs("rst_after");
        tick; dmem_resp = 1'b1;
        mid; chk_idle_outputs("rst_resp_ignored");
        tick; dmem_resp = 1'b0;
        mid; chk_idle_outputs("rst_final");

`ifdef LSQ_DMEM_PERF_EN
        chk("perf_load_after_rst", perf_load_cnt, 32'd0);
        chk("perf_store_after_rst", perf_store_cnt, 32'd0);
        chk("perf_drop_after_rst", perf_flush_drop_cnt, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

`ifdef LSQ_DMEM_PERF_EN
    // Perf counter values just before the mid-load reset: 7 loads, 4 stores, 2 drops.
    initial begin
        wait (rst === 1'b0);
        @(posedge rst);
        #0;
        chk("perf_load", perf_load_cnt, 32'd7);
        chk("perf_store", perf_store_cnt, 32'd4);
        chk("perf_drop", perf_flush_drop_cnt, 32'd2);
    end
`endif

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
